// File: rtl/head_shift_tx_pkg.sv
// Shared definitions for the tagged head-shift interface: tag layout, tag struct,
// transmit FSM states and default widths shared with the shift stage.
package head_shift_tx_pkg;

    localparam int HS_HEAD_WIDTH  = 512;
    localparam int HS_TAG_WIDTH   = 8;
    localparam int HS_SHIFT_WIDTH = 5;
    localparam int HS_CANDI_NUM   = 32;
    localparam int HS_MAX_BEATS   = 4;

    localparam int TAG_VALID_BIT  = HS_TAG_WIDTH - 1;
    localparam int TAG_SHIFT_BIT  = HS_TAG_WIDTH - 2;
    localparam int TAG_FIRST_BIT  = HS_TAG_WIDTH - 3;
    localparam int TAG_AMT_WIDTH  = HS_TAG_WIDTH - 3;

    typedef struct packed {
        logic                     valid;
        logic                     shift;
        logic                     first;
        logic [TAG_AMT_WIDTH-1:0] amount;
    } head_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_BODY  = 2'd2,
        ST_FLUSH = 2'd3
    } tx_state_t;

    // Amounts past the last legal candidate saturate to the last candidate.
    function automatic logic [HS_SHIFT_WIDTH-1:0] clamp_amt(
        input logic [HS_SHIFT_WIDTH-1:0] amt,
        input int                        candi_num
    );
        if (int'(amt) >= candi_num) begin
            return HS_SHIFT_WIDTH'(candi_num - 1);
        end else begin
            return amt;
        end
    endfunction

endpackage

// File: rtl/head_tag_pack.sv
// Combinational packing of {valid, shift, first, amount} flags and head data
// into the tagged head word {tag, data}; shared with the shift stage for re-tagging.
module head_tag_pack
    import head_shift_tx_pkg::*;
#(
    parameter int HEAD_WIDTH = HS_HEAD_WIDTH
) (
    input  logic                           valid,
    input  logic                           shift,
    input  logic                           first,
    input  logic [HS_SHIFT_WIDTH-1:0]      amount,
    input  logic [HEAD_WIDTH-1:0]          data,
    output logic [HEAD_WIDTH+HS_TAG_WIDTH-1:0] word
);

    head_tag_t tag_s;

    // Assemble tag fields and place the tag above the data.
    always_comb begin
        tag_s.valid  = valid;
        tag_s.shift  = shift;
        tag_s.first  = first;
        tag_s.amount = TAG_AMT_WIDTH'(amount);
        word         = {tag_s, data};
    end

endmodule

// File: rtl/head_shift_tx.sv
// Transmit end of the tagged head-shift interface. Every output word is registered,
// so a word appears the cycle after the FSM state/beat that produced it.
// Optional macro HEAD_SHIFT_TX_ZERO_SKIP_EN: amount 0 skips FIRST and sends VALID-only body words.
module head_shift_tx
    import head_shift_tx_pkg::*;
#(
    parameter int HEAD_WIDTH       = HS_HEAD_WIDTH,
    parameter int TAG_WIDTH        = HS_TAG_WIDTH,
    parameter int HEAD_SHIFT_WIDTH = HS_SHIFT_WIDTH,
    parameter int HEAD_CANDI_NUM   = HS_CANDI_NUM,
    parameter int MAX_BEATS        = HS_MAX_BEATS
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_pkt_valid,
    input  logic [HEAD_WIDTH-1:0]           i_pkt_data,
    input  logic                            i_pkt_sop,
    input  logic                            i_pkt_eop,
    output logic                            o_pkt_ready,
    input  logic                            i_shift_valid,
    input  logic [HEAD_SHIFT_WIDTH-1:0]     i_shift_amt,
    output logic                            o_shift_ready,
    output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
    output logic [HEAD_SHIFT_WIDTH-1:0]     o_headShift,
    output logic                            o_busy
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    tx_state_t                       state_r, state_nx_s;
    logic [CNT_W-1:0]                cnt_r, cnt_nx_s, cnt_inc_s;
    logic [HEAD_SHIFT_WIDTH-1:0]     amt_r, amt_nx_s, cmd_amt_s;
    logic [HEAD_SHIFT_WIDTH-1:0]     hs_r, hs_nx_s;
    logic [HEAD_WIDTH+TAG_WIDTH-1:0] head_r, word_s;
    logic                            pkt_ready_r, shift_ready_r, busy_r;
    logic                            sop_block_s, accept_s, shift_fire_s, body_shift_s;
    logic                            pk_valid_s, pk_shift_s, pk_first_s;
    logic [HEAD_SHIFT_WIDTH-1:0]     pk_amt_s;
    logic [HEAD_WIDTH-1:0]           pk_data_s;

    // A sop after the first body beat closes the packet; the beat is refused so it
    // stays at the input for the next command.
    assign sop_block_s  = (state_r == ST_BODY) && (cnt_r != {CNT_W{1'b0}})
                          && i_pkt_valid && i_pkt_sop;
    assign o_pkt_ready  = pkt_ready_r & ~sop_block_s;
    assign o_shift_ready = shift_ready_r;
    assign accept_s     = i_pkt_valid & o_pkt_ready;
    assign shift_fire_s = i_shift_valid & shift_ready_r;
    assign cmd_amt_s    = clamp_amt(i_shift_amt, HEAD_CANDI_NUM);
    assign cnt_inc_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef HEAD_SHIFT_TX_ZERO_SKIP_EN
    assign body_shift_s = (amt_r != {HEAD_SHIFT_WIDTH{1'b0}});
`else
    assign body_shift_s = 1'b1;
`endif

    // Next-state, counter and next output word selection.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        amt_nx_s   = amt_r;
        hs_nx_s    = {HEAD_SHIFT_WIDTH{1'b0}};
        pk_valid_s = 1'b0;
        pk_shift_s = 1'b0;
        pk_first_s = 1'b0;
        pk_amt_s   = {HEAD_SHIFT_WIDTH{1'b0}};
        pk_data_s  = {HEAD_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (shift_fire_s) begin
                    amt_nx_s = cmd_amt_s;
                    cnt_nx_s = {CNT_W{1'b0}};
`ifdef HEAD_SHIFT_TX_ZERO_SKIP_EN
                    if (cmd_amt_s == {HEAD_SHIFT_WIDTH{1'b0}}) begin
                        state_nx_s = ST_BODY;
                    end else begin
                        state_nx_s = ST_FIRST;
                    end
`else
                    state_nx_s = ST_FIRST;
`endif
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FIRST: begin
                pk_valid_s = 1'b1;
                pk_shift_s = 1'b1;
                pk_first_s = 1'b1;
                pk_amt_s   = amt_r;
                hs_nx_s    = amt_r;
                state_nx_s = ST_BODY;
            end
            ST_BODY: begin
                if (sop_block_s) begin
                    state_nx_s = ST_IDLE;
                end else if (accept_s) begin
                    pk_valid_s = 1'b1;
                    pk_shift_s = body_shift_s;
                    pk_amt_s   = amt_r;
                    pk_data_s  = i_pkt_data;
                    hs_nx_s    = amt_r;
                    cnt_nx_s   = cnt_inc_s;
                    if (i_pkt_eop) begin
                        state_nx_s = ST_IDLE;
                    end else if (cnt_inc_s == CNT_W'(MAX_BEATS)) begin
                        state_nx_s = ST_FLUSH;
                    end else begin
                        state_nx_s = ST_BODY;
                    end
                end else begin
                    state_nx_s = ST_BODY;
                end
            end
            ST_FLUSH: begin
                if (accept_s && i_pkt_eop) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_FLUSH;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    head_tag_pack #(
        .HEAD_WIDTH (HEAD_WIDTH)
    ) u_pack (
        .valid  (pk_valid_s),
        .shift  (pk_shift_s),
        .first  (pk_first_s),
        .amount (pk_amt_s),
        .data   (pk_data_s),
        .word   (word_s)
    );

    // State, counters, handshake readies and registered output word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            amt_r         <= {HEAD_SHIFT_WIDTH{1'b0}};
            hs_r          <= {HEAD_SHIFT_WIDTH{1'b0}};
            head_r        <= {(HEAD_WIDTH+TAG_WIDTH){1'b0}};
            pkt_ready_r   <= 1'b0;
            shift_ready_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            cnt_r         <= cnt_nx_s;
            amt_r         <= amt_nx_s;
            hs_r          <= hs_nx_s;
            head_r        <= word_s;
            pkt_ready_r   <= (state_nx_s == ST_BODY) || (state_nx_s == ST_FLUSH);
            shift_ready_r <= (state_nx_s == ST_IDLE);
            busy_r        <= (state_r != ST_IDLE);
        end
    end

    assign o_head      = head_r;
    assign o_headShift = hs_r;
    assign o_busy      = busy_r;

endmodule

// File: tb/tb_head_shift_tx.sv
// Directed self-checking bench for head_shift_tx: per-cycle output log compared
// against hand-built expected word lists.
module tb_head_shift_tx;
    import head_shift_tx_pkg::*;

    localparam int HW    = 512;
    localparam int WW    = HW + HS_TAG_WIDTH;
    localparam int CANDI = 24;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_pkt_valid, i_pkt_sop, i_pkt_eop, o_pkt_ready;
    logic [HW-1:0] i_pkt_data;
    logic          i_shift_valid, o_shift_ready;
    logic [4:0]    i_shift_amt;
    logic [WW-1:0] o_head;
    logic [4:0]    o_headShift;
    logic          o_busy;

    head_shift_tx #(
        .HEAD_WIDTH     (HW),
        .HEAD_CANDI_NUM (CANDI),
        .MAX_BEATS      (4)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_pkt_valid   (i_pkt_valid),
        .i_pkt_data    (i_pkt_data),
        .i_pkt_sop     (i_pkt_sop),
        .i_pkt_eop     (i_pkt_eop),
        .o_pkt_ready   (o_pkt_ready),
        .i_shift_valid (i_shift_valid),
        .i_shift_amt   (i_shift_amt),
        .o_shift_ready (o_shift_ready),
        .o_head        (o_head),
        .o_headShift   (o_headShift),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [WW-1:0] head;
        logic [4:0]    hs;
        logic          busy;
    } samp_t;

    samp_t         log_q[$];
    bit            log_en = 1'b0;
    logic [WW-1:0] words_q[$];
    logic [4:0]    hs_q[$];
    logic [WW-1:0] exp_q[$];
    logic [4:0]    exp_hs_q[$];
    int            busy_cnt, span, zeros;

    always @(negedge i_clk) begin
        if (log_en) log_q.push_back(samp_t'({o_head, o_headShift, o_busy}));
    end

    task automatic check_eq(string tag, logic [WW-1:0] obs, logic [WW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HW-1:0] mk_data(int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {16{w}};
    endfunction

    function automatic logic [WW-1:0] first_w(logic [4:0] a);
        return {3'b111, a, {HW{1'b0}}};
    endfunction

    function automatic logic [WW-1:0] body_w(logic [4:0] a, logic [HW-1:0] d);
        return {3'b110, a, d};
    endfunction

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic expect_word(logic [WW-1:0] w, logic [4:0] h);
        exp_q.push_back(w);
        exp_hs_q.push_back(h);
    endtask

    task automatic start_log;
        log_q.delete();
        exp_q.delete();
        exp_hs_q.delete();
        log_en = 1'b1;
    endtask

    task automatic end_log;
        int first_i, last_i;
        repeat (4) tick();
        log_en = 1'b0;
        words_q.delete();
        hs_q.delete();
        busy_cnt = 0;
        first_i  = -1;
        last_i   = -1;
        foreach (log_q[i]) begin
            if (log_q[i].busy) busy_cnt++;
            if (log_q[i].head != '0) begin
                words_q.push_back(log_q[i].head);
                hs_q.push_back(log_q[i].hs);
                if (first_i < 0) first_i = i;
                last_i = i;
            end
        end
        span  = (first_i < 0) ? 0 : (last_i - first_i + 1);
        zeros = span - words_q.size();
    endtask

    task automatic check_words(string tag);
        check_eq({tag, "_count"}, WW'(words_q.size()), WW'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [WW-1:0] w;
            logic [4:0]    h;
            w = (i < words_q.size()) ? words_q[i] : '0;
            h = (i < hs_q.size()) ? hs_q[i] : 5'd0;
            check_eq($sformatf("%s_word%0d", tag, i), w, exp_q[i]);
            check_eq($sformatf("%s_shift%0d", tag, i), WW'(h), WW'(exp_hs_q[i]));
        end
    endtask

    task automatic send_cmd(logic [4:0] a);
        bit ok;
        ok = 1'b0;
        i_shift_valid = 1'b1;
        i_shift_amt   = a;
        for (int k = 0; k < 20; k++) begin
            if (o_shift_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        i_shift_valid = 1'b0;
        check_eq("cmd_accept", WW'(ok), WW'(1));
    endtask

    task automatic send_beat(logic [HW-1:0] d, logic sop, logic eop);
        bit ok;
        ok = 1'b0;
        i_pkt_valid = 1'b1;
        i_pkt_data  = d;
        i_pkt_sop   = sop;
        i_pkt_eop   = eop;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (o_pkt_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        i_pkt_valid = 1'b0;
        i_pkt_sop   = 1'b0;
        i_pkt_eop   = 1'b0;
        check_eq("beat_accept", WW'(ok), WW'(1));
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_pkt_valid   = 1'b0;
        i_pkt_data    = '0;
        i_pkt_sop     = 1'b0;
        i_pkt_eop     = 1'b0;
        i_shift_valid = 1'b0;
        i_shift_amt   = 5'd0;
        #12;
        check_eq("rst_head", o_head, '0);
        check_eq("rst_shift", WW'(o_headShift), WW'(0));
        check_eq("rst_busy", WW'(o_busy), WW'(0));
        check_eq("rst_pkt_ready", WW'(o_pkt_ready), WW'(0));
        check_eq("rst_shift_ready", WW'(o_shift_ready), WW'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        check_eq("idle_shift_ready", WW'(o_shift_ready), WW'(1));
        check_eq("idle_pkt_ready", WW'(o_pkt_ready), WW'(0));

        // Basic: amount 5, three back-to-back beats.
        start_log();
        send_cmd(5'd5);
        for (int i = 0; i < 3; i++) send_beat(mk_data(i), i == 0, i == 2);
        end_log();
        expect_word(first_w(5'd5), 5'd5);
        for (int i = 0; i < 3; i++) expect_word(body_w(5'd5, mk_data(i)), 5'd5);
        check_words("basic");
        check_eq("basic_bubbles", WW'(zeros), WW'(0));
        check_eq("basic_busy", WW'(busy_cnt), WW'(4));
        check_eq("basic_idle", WW'(o_shift_ready), WW'(1));

        // Single sop&eop beat.
        start_log();
        send_cmd(5'd1);
        send_beat(mk_data(10), 1'b1, 1'b1);
        end_log();
        expect_word(first_w(5'd1), 5'd1);
        expect_word(body_w(5'd1, mk_data(10)), 5'd1);
        check_words("single");
        check_eq("single_busy", WW'(busy_cnt), WW'(2));

        // Truncation: six beats, only four body words.
        start_log();
        send_cmd(5'd3);
        for (int i = 0; i < 6; i++) send_beat(mk_data(20 + i), i == 0, i == 5);
        end_log();
        expect_word(first_w(5'd3), 5'd3);
        for (int i = 0; i < 4; i++) expect_word(body_w(5'd3, mk_data(20 + i)), 5'd3);
        check_words("trunc");
        check_eq("trunc_busy", WW'(busy_cnt), WW'(7));
        check_eq("trunc_idle", WW'(o_shift_ready), WW'(1));

        // Clamp 30 -> 23 with one idle cycle between beats.
        start_log();
        send_cmd(5'd30);
        for (int i = 0; i < 3; i++) begin
            send_beat(mk_data(30 + i), i == 0, i == 2);
            if (i < 2) tick();
        end
        end_log();
        expect_word(first_w(5'd23), 5'd23);
        for (int i = 0; i < 3; i++) expect_word(body_w(5'd23, mk_data(30 + i)), 5'd23);
        check_words("gap");
        check_eq("gap_span", WW'(span), WW'(6));
        check_eq("gap_bubbles", WW'(zeros), WW'(2));

        // A new sop in BODY ends the packet and waits for the next command.
        start_log();
        send_cmd(5'd2);
        send_beat(mk_data(40), 1'b1, 1'b0);
        send_beat(mk_data(41), 1'b0, 1'b0);
        i_pkt_valid = 1'b1;
        i_pkt_data  = mk_data(42);
        i_pkt_sop   = 1'b1;
        i_pkt_eop   = 1'b1;
        #1;
        check_eq("sop_refused", WW'(o_pkt_ready), WW'(0));
        send_cmd(5'd7);
        send_beat(mk_data(42), 1'b1, 1'b1);
        end_log();
        expect_word(first_w(5'd2), 5'd2);
        expect_word(body_w(5'd2, mk_data(40)), 5'd2);
        expect_word(body_w(5'd2, mk_data(41)), 5'd2);
        expect_word(first_w(5'd7), 5'd7);
        expect_word(body_w(5'd7, mk_data(42)), 5'd7);
        check_words("sop");

        // Asynchronous reset during the third beat.
        send_cmd(5'd4);
        send_beat(mk_data(50), 1'b1, 1'b0);
        send_beat(mk_data(51), 1'b0, 1'b0);
        i_pkt_valid = 1'b1;
        i_pkt_data  = mk_data(52);
        #2;
        check_eq("pre_rst_busy", WW'(o_busy), WW'(1));
        i_rst_n = 1'b0;
        #1;
        check_eq("mid_rst_head", o_head, '0);
        check_eq("mid_rst_pkt_ready", WW'(o_pkt_ready), WW'(0));
        check_eq("mid_rst_busy", WW'(o_busy), WW'(0));
        i_pkt_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        start_log();
        send_cmd(5'd6);
        send_beat(mk_data(53), 1'b1, 1'b1);
        end_log();
        expect_word(first_w(5'd6), 5'd6);
        expect_word(body_w(5'd6, mk_data(53)), 5'd6);
        check_words("post_rst");

        // Amount zero, two beats.
        start_log();
        send_cmd(5'd0);
        send_beat(mk_data(60), 1'b1, 1'b0);
        send_beat(mk_data(61), 1'b0, 1'b1);
        end_log();
`ifdef HEAD_SHIFT_TX_ZERO_SKIP_EN
        expect_word({3'b100, 5'd0, mk_data(60)}, 5'd0);
        expect_word({3'b100, 5'd0, mk_data(61)}, 5'd0);
        check_words("zero");
        check_eq("zero_busy", WW'(busy_cnt), WW'(2));
`else
        expect_word(first_w(5'd0), 5'd0);
        expect_word(body_w(5'd0, mk_data(60)), 5'd0);
        expect_word(body_w(5'd0, mk_data(61)), 5'd0);
        check_words("zero");
        check_eq("zero_busy", WW'(busy_cnt), WW'(3));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
